// File: rtl/gain_st1_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-cycle gain stage among N_REQ requesters.
// Issues the granted ISI with an address-mismatch gate, captures the result and counts drops.
module gain_st1_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned BIT_ISI  = 8,
  parameter int unsigned BIT_ADDR = 8,
  parameter int unsigned BIT_ID   = 2,
  parameter int unsigned BIT_DROP = 16
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      cfg_we,
  input  logic [BIT_ADDR-1:0]       cfg_addr,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*BIT_ISI-1:0]  req_isi,
  input  logic [N_REQ*BIT_ADDR-1:0] req_addr,
  output logic [N_REQ-1:0]          gnt,
  output logic [BIT_ISI-1:0]        st_isi_x,
  output logic                      st_comp_addr_x,
  input  logic [BIT_ISI-1:0]        st_isi_z,
  input  logic                      st_valid,
  output logic                      res_valid,
  output logic [BIT_ISI-1:0]        res_isi,
  output logic [BIT_ID-1:0]         res_id,
  input  logic                      res_ready,
  output logic                      busy,
  output logic [BIT_DROP-1:0]       drop_cnt
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StHold} state_e;

  state_e              state_q, state_d;
  logic [BIT_ADDR-1:0] target_q, target_d;
  logic [BIT_ID-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BIT_ISI-1:0]  isi_q, isi_d;
  logic [BIT_ADDR-1:0] addr_q, addr_d;
  logic [BIT_ID-1:0]   id_q, id_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [BIT_ISI-1:0]  res_isi_q, res_isi_d;
  logic [BIT_ID-1:0]   res_id_q, res_id_d;
  logic [BIT_DROP-1:0] drop_q, drop_d;

  logic                found;
  logic [BIT_ID-1:0]   sel;
  int unsigned         idx;

  // Search upward from rr_ptr with wrap; only ids below N_REQ are ever visited.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = BIT_ID'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    target_d  = cfg_we ? cfg_addr : target_q;
    rr_ptr_d  = rr_ptr_q;
    isi_d     = isi_q;
    addr_d    = addr_q;
    id_d      = id_q;
    gnt_d     = '0;
    res_isi_d = res_isi_q;
    res_id_d  = res_id_q;
    drop_d    = drop_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          isi_d      = req_isi[int'(sel)*BIT_ISI +: BIT_ISI];
          addr_d     = req_addr[int'(sel)*BIT_ADDR +: BIT_ADDR];
          id_d       = sel;
          gnt_d[sel] = 1'b1;
          rr_ptr_d   = BIT_ID'((int'(sel) + 1) % N_REQ);
          state_d    = StIssue;
        end
      end
      StIssue: state_d = StCapture;
      StCapture: begin
        if (st_valid) begin
          res_isi_d = st_isi_z;
          res_id_d  = id_q;
          state_d   = StHold;
        end else begin
          if (drop_q != '1) drop_d = drop_q + 1'b1;
          state_d = StIdle;
        end
      end
      StHold: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= StIdle;
      target_q  <= '0;
      rr_ptr_q  <= '0;
      isi_q     <= '0;
      addr_q    <= '0;
      id_q      <= '0;
      gnt_q     <= '0;
      res_isi_q <= '0;
      res_id_q  <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      rr_ptr_q  <= rr_ptr_d;
      isi_q     <= isi_d;
      addr_q    <= addr_d;
      id_q      <= id_d;
      gnt_q     <= gnt_d;
      res_isi_q <= res_isi_d;
      res_id_q  <= res_id_d;
      drop_q    <= drop_d;
    end
  end

  // Gate the stage off outside ISSUE so it only ever sees one event per grant.
  assign st_comp_addr_x = (state_q == StIssue) ? (addr_q != target_q) : 1'b1;
  assign st_isi_x       = isi_q;
  assign gnt            = gnt_q;
  assign res_valid      = (state_q == StHold);
  assign res_isi        = res_isi_q;
  assign res_id         = res_id_q;
  assign busy           = (state_q != StIdle);
  assign drop_cnt       = drop_q;

endmodule

// File: tb/tb_gain_st1_arbiter.sv
// Directed bench for gain_st1_arbiter with a behavioural single-cycle gain stage attached.
module tb_gain_st1_arbiter;

  localparam int unsigned N_REQ = 4;

  logic                clk = 1'b0;
  logic                clr;
  logic                cfg_we;
  logic [7:0]          cfg_addr;
  logic [N_REQ-1:0]    req;
  logic [N_REQ*8-1:0]  req_isi;
  logic [N_REQ*8-1:0]  req_addr;
  logic [N_REQ-1:0]    gnt;
  logic [7:0]          st_isi_x;
  logic                st_comp_addr_x;
  logic [7:0]          st_isi_z;
  logic                st_valid;
  logic                res_valid;
  logic [7:0]          res_isi;
  logic [1:0]          res_id;
  logic                res_ready;
  logic                busy;
  logic [15:0]         drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  gain_st1_arbiter dut (
    .clk            (clk),
    .clr            (clr),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .req            (req),
    .req_isi        (req_isi),
    .req_addr       (req_addr),
    .gnt            (gnt),
    .st_isi_x       (st_isi_x),
    .st_comp_addr_x (st_comp_addr_x),
    .st_isi_z       (st_isi_z),
    .st_valid       (st_valid),
    .res_valid      (res_valid),
    .res_isi        (res_isi),
    .res_id         (res_id),
    .res_ready      (res_ready),
    .busy           (busy),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  // Gain stage: registers isi, valid only when the address gate is open.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st_isi_z <= '0;
      st_valid <= 1'b0;
    end else begin
      st_isi_z <= st_isi_x;
      st_valid <= ~st_comp_addr_x;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic [7:0] isi, input logic [7:0] addr);
    req_isi[i*8 +: 8]  = isi;
    req_addr[i*8 +: 8] = addr;
  endtask

  task automatic write_target(input logic [7:0] a);
    cfg_we   = 1'b1;
    cfg_addr = a;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  // Steps negedges until gnt is seen; returns the number of cycles waited.
  task automatic wait_gnt(output int n);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n++;
      if (gnt != '0) break;
    end
    if (gnt == '0) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  int n;

  initial begin
    clr = 1'b1; cfg_we = 1'b0; cfg_addr = '0; req = '0;
    req_isi = '0; req_addr = '0; res_ready = 1'b0;
    #12;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_comp", 32'(st_comp_addr_x), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_resv", 32'(res_valid), 32'h0);
    check("rst_drop", 32'(drop_cnt), 32'h0);
    check("rst_isix", 32'(st_isi_x), 32'h0);
    @(negedge clk);
    clr = 1'b0;
    write_target(8'h05);

    // 1: matching event from requester 2
    set_lane(2, 8'h3C, 8'h05);
    req = 4'b0100;
    @(negedge clk);
    check("t1_gnt", 32'(gnt), 32'h4);
    check("t1_comp", 32'(st_comp_addr_x), 32'h0);
    check("t1_isix", 32'(st_isi_x), 32'h3C);
    req = '0;
    @(negedge clk);
    check("t1_gnt_off", 32'(gnt), 32'h0);
    check("t1_resv_early", 32'(res_valid), 32'h0);
    @(negedge clk);
    check("t1_resv", 32'(res_valid), 32'h1);
    check("t1_isi", 32'(res_isi), 32'h3C);
    check("t1_id", 32'(res_id), 32'h2);
    res_ready = 1'b1;
    @(negedge clk);
    check("t1_resv_off", 32'(res_valid), 32'h0);
    check("t1_idle", 32'(busy), 32'h0);

    // 2: mismatching event from requester 1 is dropped
    res_ready = 1'b0;
    set_lane(1, 8'h11, 8'h07);
    req = 4'b0010;
    @(negedge clk);
    check("t2_gnt", 32'(gnt), 32'h2);
    check("t2_comp", 32'(st_comp_addr_x), 32'h1);
    req = '0;
    @(negedge clk);
    check("t2_busy", 32'(busy), 32'h1);
    @(negedge clk);
    check("t2_idle", 32'(busy), 32'h0);
    check("t2_resv", 32'(res_valid), 32'h0);
    check("t2_drop", 32'(drop_cnt), 32'h1);

    // 3: round-robin from a fresh pointer, all requesters matching
    do_reset();
    check("t3_drop_clr", 32'(drop_cnt), 32'h0);
    write_target(8'h05);
    for (int i = 0; i < N_REQ; i++) set_lane(i, 8'(8'h10 + i), 8'h05);
    res_ready = 1'b1;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_gnt(n);
      check($sformatf("t3_gnt%0d", g), 32'(gnt), 32'(1 << (g % N_REQ)));
      check($sformatf("t3_gap%0d", g), 32'(n), (g == 0) ? 32'd1 : 32'd2);
      if (g == 4) req = '0;
      @(negedge clk);
      @(negedge clk);
      check($sformatf("t3_resv%0d", g), 32'(res_valid), 32'h1);
      check($sformatf("t3_id%0d", g), 32'(res_id), 32'(g % N_REQ));
      check($sformatf("t3_isi%0d", g), 32'(res_isi), 32'(8'h10 + (g % N_REQ)));
    end
    @(negedge clk);
    check("t3_idle", 32'(busy), 32'h0);

    // 4: backpressure holds the result and blocks further grants
    res_ready = 1'b0;
    set_lane(3, 8'hA5, 8'h05);
    req = 4'b1000;
    @(negedge clk);
    check("t4_gnt", 32'(gnt), 32'h8);
    set_lane(0, 8'h5A, 8'h05);
    req = 4'b0001;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_hold_v", 32'(res_valid), 32'h1);
      check("t4_hold_isi", 32'(res_isi), 32'hA5);
      check("t4_hold_gnt", 32'(gnt), 32'h0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("t4_release", 32'(res_valid), 32'h0);
    @(negedge clk);
    check("t4_next_gnt", 32'(gnt), 32'h1);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    check("t4_next_id", 32'(res_id), 32'h0);
    check("t4_next_isi", 32'(res_isi), 32'h5A);
    @(negedge clk);

    // 5: target write during ISSUE only affects the following event
    res_ready = 1'b0;
    set_lane(1, 8'h77, 8'h07);
    req = 4'b0010;
    @(negedge clk);
    check("t5_gnt", 32'(gnt), 32'h2);
    req = '0;
    cfg_we = 1'b1;
    cfg_addr = 8'h07;
    @(negedge clk);
    cfg_we = 1'b0;
    @(negedge clk);
    check("t5_dropped", 32'(res_valid), 32'h0);
    check("t5_drop", 32'(drop_cnt), 32'h1);
    req = 4'b0010;
    @(negedge clk);
    check("t5_gnt2", 32'(gnt), 32'h2);
    check("t5_comp2", 32'(st_comp_addr_x), 32'h0);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    check("t5_resv", 32'(res_valid), 32'h1);
    check("t5_isi", 32'(res_isi), 32'h77);
    check("t5_id", 32'(res_id), 32'h1);

    // 6: asynchronous clear while holding a result
    #2 clr = 1'b1;
    #1;
    check("t6_resv", 32'(res_valid), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_drop", 32'(drop_cnt), 32'h0);
    check("t6_comp", 32'(st_comp_addr_x), 32'h1);
    check("t6_isi", 32'(res_isi), 32'h0);
    check("t6_isix", 32'(st_isi_x), 32'h0);
    @(negedge clk);
    check("t6_no_gnt", 32'(gnt), 32'h0);
    clr = 1'b0;
    // Target cleared to 0, so an address-0 event must now be delivered.
    set_lane(2, 8'h42, 8'h00);
    req = 4'b0100;
    @(negedge clk);
    check("t6_gnt", 32'(gnt), 32'h4);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    check("t6_tgt_resv", 32'(res_valid), 32'h1);
    check("t6_tgt_isi", 32'(res_isi), 32'h42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
